flow_seq_ctrl: RTL and testbench
================================

Name: flow_seq_ctrl

Overview:
Parametrised data-flow sequencer that steps a processing chain through NUM_STG stages. Each stage waits until every channel in its runtime-programmable mask acknowledges, then issues a one-cycle start pulse to those channels and advances. Used as the top-level pipeline controller that fires the sub-blocks in a fixed, configurable order. Supersedes the fixed 4-state/5-channel controller.

Parameters:
NUM_CH, 5, number of handshake channels (ack/start pairs), 1..16
NUM_STG, 4, number of sequence stages, 2..16
STG_W, clog2(NUM_STG) (min 1), stage index width, derived
TIMEOUT_CYC, 1024, max wait cycles per stage before watchdog fires (only with FLOW_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
en  in  1  sequencer enable; low = hold state, no starts
clr  in  1  synchronous clear to stage 0
stage_mask  in  NUM_STG*NUM_CH  channel mask per stage; bits [s*NUM_CH +: NUM_CH] belong to stage s
ack  in  NUM_CH  per-channel ready/acknowledge, level
start  out  NUM_CH  per-channel start pulse, registered
stage  out  STG_W  current stage index
frame_done  out  1  one-cycle pulse when the last stage completes and the index wraps to 0
timeout_err  out  1  sticky watchdog error (tied 0 without FLOW_SEQ_TIMEOUT_EN)

Behaviour:
- Reset: stage=0, start=0, frame_done=0, timeout_err=0, wait counter=0.
- All outputs registered; no combinational path from ack to start.
- Per cycle with en=1, clr=0: m = stage_mask slice for current stage. If (ack & m) == m: at next edge start<=m, stage<=stage+1 (wraps NUM_STG-1 -> 0), frame_done<=1 on wrap. Else start<=0, stage holds.
- Latency: ack condition met in cycle k -> start high in cycle k+1 only, one cycle wide; stage updates at the same edge.
- Empty mask stage (m=0): condition trivially true; acts as one-cycle delay stage with start=0.
- Stage values >= NUM_STG (non-power-of-2 NUM_STG): unreachable; if reached, return to 0 next cycle, no starts.
- en=0: stage and wait counter hold, start=0, frame_done=0; resume evaluating when en returns.
- clr=1: stage<=0, start<=0, frame_done<=0, wait counter<=0, timeout_err<=0; clr has priority over en and advance.
- ack held high across stages is legal; each stage evaluates only its own mask.
- stage_mask sampled each cycle; changing it mid-stage affects the current stage's condition immediately. Software changes it only while en=0.
- reset asserted mid-sequence: immediate return to reset values, no partial start pulse.

Optional Feature:
FLOW_SEQ_TIMEOUT_EN: per-stage wait counter increments each en=1 cycle the condition is false; clears on advance. When it reaches TIMEOUT_CYC-1 with condition still false: timeout_err<=1 (sticky until clr/reset), stage<=0, start=0, no frame_done. Without the macro: no counter, timeout_err tied 0, stage waits indefinitely.

Decomposition:
- Package flow_seq_pkg: default NUM_CH/NUM_STG/TIMEOUT_CYC, clog2 function, mask-slice helper function.
- One sub-module: flow_seq_wdog (wait counter + timeout compare, inputs run/clear, output expire), instantiated only under FLOW_SEQ_TIMEOUT_EN.

Test Plan:
- Default params, masks s0=00011, s1=00100, s2=11000, s3=00000; all ack=1 from reset release -> start sequence 00011,00100,11000,00000, frame_done high on the 4th cycle, repeating every 4 cycles.
- Stage 0 with ack=00001 for 10 cycles then 00011 -> stage stays 0, start=0 for 10 cycles; start=00011 exactly one cycle after ack completes.
- en dropped for 5 cycles while stage=2 -> stage holds 2, start=0; after en=1 with ack=11000 -> start=11000 next cycle.
- clr pulsed in the cycle where stage 1's condition is met -> stage=0, start=0 next cycle, no start=00100.
- With FLOW_SEQ_TIMEOUT_EN, TIMEOUT_CYC=8, stage 1 ack never asserted -> timeout_err=1 after 8 waiting cycles, stage=0; remains 1 until clr.
- reset asserted while start=11000 -> start, stage, frame_done all 0 asynchronously.

Source files
------------

// File: rtl/flow_seq_pkg.sv
// Shared defaults and helpers for the flow sequencer (flow_seq_ctrl, flow_seq_wdog).
// Optional watchdog is enabled by defining FLOW_SEQ_TIMEOUT_EN.
package flow_seq_pkg;

    localparam int DEF_NUM_CH      = 5;
    localparam int DEF_NUM_STG     = 4;
    localparam int DEF_TIMEOUT_CYC = 1024;

    localparam int MAX_CH     = 16;
    localparam int MAX_STG    = 16;
    localparam int MAX_MASK_W = MAX_CH * MAX_STG;

    // Index width for 'value' distinct states, never below one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((32'sd1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Channel mask of stage 'stg' from a zero-padded flat mask vector.
    // Out-of-range stages yield an empty mask.
    function automatic logic [MAX_CH-1:0] mask_slice(
        input logic [MAX_MASK_W-1:0] masks,
        input int unsigned           stg,
        input int unsigned           nch
    );
        logic [MAX_CH-1:0] keep;
        keep = ({{(MAX_CH-1){1'b0}}, 1'b1} << nch) - {{(MAX_CH-1){1'b0}}, 1'b1};
        return MAX_CH'(masks >> (stg * nch)) & keep;
    endfunction

endpackage

// File: rtl/flow_seq_wdog.sv
// Per-stage wait counter for the flow sequencer; only built with FLOW_SEQ_TIMEOUT_EN.
// expire is high in the waiting cycle that completes TIMEOUT_CYC waits.
module flow_seq_wdog
    import flow_seq_pkg::*;
#(
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int CNT_W       = clog2_min1(TIMEOUT_CYC)
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expire
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    assign expire = run & (32'(cnt_r) == TIMEOUT_CYC - 1);

    // Next wait count: restart on clear or expiry, count while waiting.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear || expire) begin
            cnt_nxt_s = {CNT_W{1'b0}};
        end else if (run) begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/flow_seq_ctrl.sv
// Stage sequencer: waits for all masked acks of the current stage, pulses start, advances.
// Define FLOW_SEQ_TIMEOUT_EN to add the per-stage watchdog (flow_seq_wdog).
module flow_seq_ctrl
    import flow_seq_pkg::*;
#(
    parameter  int NUM_CH      = DEF_NUM_CH,
    parameter  int NUM_STG     = DEF_NUM_STG,
    parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int STG_W       = clog2_min1(NUM_STG)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      clr,
    input  logic [NUM_STG*NUM_CH-1:0] stage_mask,
    input  logic [NUM_CH-1:0]         ack,
    output logic [NUM_CH-1:0]         start,
    output logic [STG_W-1:0]          stage,
    output logic                      frame_done,
    output logic                      timeout_err
);

    localparam int MASK_W = NUM_STG * NUM_CH;

    logic [MAX_MASK_W-1:0] mask_ext_s;
    logic [NUM_CH-1:0]     m_s;
    logic                  cond_s;
    logic                  valid_s;
    logic                  last_s;
    logic                  expire_s;

    logic [NUM_CH-1:0]     start_r,  start_nxt_s;
    logic [STG_W-1:0]      stage_r,  stage_nxt_s;
    logic                  fd_r,     fd_nxt_s;
    logic                  terr_r,   terr_nxt_s;

    generate
        if (MASK_W < MAX_MASK_W) begin : g_pad
            assign mask_ext_s = {{(MAX_MASK_W-MASK_W){1'b0}}, stage_mask};
        end else begin : g_full
            assign mask_ext_s = stage_mask;
        end
    endgenerate

    assign m_s     = NUM_CH'(mask_slice(mask_ext_s, 32'(stage_r), NUM_CH));
    assign cond_s  = ((ack & m_s) == m_s);
    assign valid_s = (32'(stage_r) < NUM_STG);
    assign last_s  = (32'(stage_r) == NUM_STG - 1);

`ifdef FLOW_SEQ_TIMEOUT_EN
    logic wd_run_s;
    logic wd_clear_s;

    // Waiting only counts while enabled in a real stage; any advance restarts it.
    assign wd_run_s   = en & ~clr & valid_s & ~cond_s;
    assign wd_clear_s = clr | ~valid_s | (en & cond_s);

    flow_seq_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .reset  (reset),
        .run    (wd_run_s),
        .clear  (wd_clear_s),
        .expire (expire_s)
    );
`else
    assign expire_s = 1'b0;
`endif

    // Next-state: clr beats everything, then enable, stray index, watchdog, advance.
    always_comb begin
        start_nxt_s = {NUM_CH{1'b0}};
        stage_nxt_s = stage_r;
        fd_nxt_s    = 1'b0;
        terr_nxt_s  = terr_r;
        if (clr) begin
            stage_nxt_s = {STG_W{1'b0}};
            terr_nxt_s  = 1'b0;
        end else if (!en) begin
            stage_nxt_s = stage_r;
        end else if (!valid_s) begin
            stage_nxt_s = {STG_W{1'b0}};
        end else if (expire_s) begin
            stage_nxt_s = {STG_W{1'b0}};
            terr_nxt_s  = 1'b1;
        end else if (cond_s) begin
            start_nxt_s = m_s;
            fd_nxt_s    = last_s;
            stage_nxt_s = last_s ? {STG_W{1'b0}} : (stage_r + STG_W'(1));
        end else begin
            stage_nxt_s = stage_r;
        end
    end

    // Output and state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_r <= {NUM_CH{1'b0}};
            stage_r <= {STG_W{1'b0}};
            fd_r    <= 1'b0;
            terr_r  <= 1'b0;
        end else begin
            start_r <= start_nxt_s;
            stage_r <= stage_nxt_s;
            fd_r    <= fd_nxt_s;
            terr_r  <= terr_nxt_s;
        end
    end

    assign start       = start_r;
    assign stage       = stage_r;
    assign frame_done  = fd_r;
    assign timeout_err = terr_r;

endmodule

// File: tb/tb_flow_seq_ctrl.sv
// Bench for flow_seq_ctrl with NUM_CH=5, NUM_STG=4, TIMEOUT_CYC=8; vector table plus corner sequences.
module tb_flow_seq_ctrl;

    typedef struct packed {
        logic [4:0] start;
        logic [1:0] stage;
        logic       fd;
        logic       terr;
    } exp_t;

    typedef struct {
        logic       en;
        logic       clr;
        logic [4:0] ack;
        exp_t       e;
    } vec_t;

`ifdef FLOW_SEQ_TIMEOUT_EN
    localparam int WAIT_N = 6;
`else
    localparam int WAIT_N = 10;
`endif

    logic        clk;
    logic        reset;
    logic        en;
    logic        clr;
    logic [19:0] stage_mask;
    logic [4:0]  ack;
    logic [4:0]  start;
    logic [1:0]  stage;
    logic        frame_done;
    logic        timeout_err;

    int   passed;
    int   total;
    vec_t tbl[$];
    exp_t exp_q[$];

    flow_seq_ctrl #(
        .NUM_CH      (5),
        .NUM_STG     (4),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .clr         (clr),
        .stage_mask  (stage_mask),
        .ack         (ack),
        .start       (start),
        .stage       (stage),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        total = total + 1;
        if (act !== req) begin
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end else begin
            passed = passed + 1;
        end
    endtask

    task automatic add(input logic en_i, input logic clr_i, input logic [4:0] ack_i,
                       input logic [4:0] s, input logic [1:0] g, input logic f, input logic t);
        vec_t v;
        v.en  = en_i;
        v.clr = clr_i;
        v.ack = ack_i;
        v.e   = '{start: s, stage: g, fd: f, terr: t};
        tbl.push_back(v);
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input string name, input logic en_i, input logic clr_i,
                        input logic [4:0] ack_i, input exp_t e);
        exp_t want;
        @(negedge clk);
        en  = en_i;
        clr = clr_i;
        ack = ack_i;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total = total + 1;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            want = exp_q.pop_front();
            check(name, {7'd0, start, stage, frame_done, timeout_err}, {7'd0, want});
        end
    endtask

    task automatic s(input string name, input logic en_i, input logic clr_i, input logic [4:0] ack_i,
                     input logic [4:0] st, input logic [1:0] g, input logic f, input logic t);
        step(name, en_i, clr_i, ack_i, '{start: st, stage: g, fd: f, terr: t});
    endtask

    initial begin
        passed     = 0;
        total      = 0;
        clk        = 1'b0;
        reset      = 1'b1;
        en         = 1'b0;
        clr        = 1'b0;
        ack        = 5'b00000;
        stage_mask = {5'b00000, 5'b11000, 5'b00100, 5'b00011};

        // Free-running with every ack high: 00011, 00100, 11000, 00000 + frame_done.
        for (int f = 0; f < 2; f++) begin
            add(1'b1, 1'b0, 5'b11111, 5'b00011, 2'd1, 1'b0, 1'b0);
            add(1'b1, 1'b0, 5'b11111, 5'b00100, 2'd2, 1'b0, 1'b0);
            add(1'b1, 1'b0, 5'b11111, 5'b11000, 2'd3, 1'b0, 1'b0);
            add(1'b1, 1'b0, 5'b11111, 5'b00000, 2'd0, 1'b1, 1'b0);
        end
        // Partial ack holds stage 0, completion fires next cycle.
        for (int i = 0; i < WAIT_N; i++) begin
            add(1'b1, 1'b0, 5'b00001, 5'b00000, 2'd0, 1'b0, 1'b0);
        end
        add(1'b1, 1'b0, 5'b00011, 5'b00011, 2'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b00100, 5'b00100, 2'd2, 1'b0, 1'b0);
        // Enable low at stage 2 holds everything.
        for (int i = 0; i < 5; i++) begin
            add(1'b0, 1'b0, 5'b11111, 5'b00000, 2'd2, 1'b0, 1'b0);
        end
        add(1'b1, 1'b0, 5'b11000, 5'b11000, 2'd3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b00000, 5'b00000, 2'd0, 1'b1, 1'b0);
        // clr in the cycle stage 1 would fire.
        add(1'b1, 1'b0, 5'b00011, 5'b00011, 2'd1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 5'b11111, 5'b00000, 2'd0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b00000, 5'b00000, 2'd0, 1'b0, 1'b0);
        // Stage 1 ignores acks outside its own mask.
        add(1'b1, 1'b0, 5'b00011, 5'b00011, 2'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b11011, 5'b00000, 2'd1, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b00100, 5'b00100, 2'd2, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b11000, 5'b11000, 2'd3, 1'b0, 1'b0);
        add(1'b1, 1'b0, 5'b11111, 5'b00000, 2'd0, 1'b1, 1'b0);

        #12;
        check("reset_start", {11'd0, start}, 16'h0000);
        check("reset_state", {13'd0, stage, frame_done}, 16'h0000);
        check("reset_terr", {15'd0, timeout_err}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        s("idle_en0", 1'b0, 1'b0, 5'b11111, 5'b00000, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("vec[%0d]", i), tbl[i].en, tbl[i].clr, tbl[i].ack, tbl[i].e);
        end

        // Asynchronous reset while start=11000 is on the outputs.
        s("pre_rst0", 1'b1, 1'b0, 5'b00011, 5'b00011, 2'd1, 1'b0, 1'b0);
        s("pre_rst1", 1'b1, 1'b0, 5'b00100, 5'b00100, 2'd2, 1'b0, 1'b0);
        s("pre_rst2", 1'b1, 1'b0, 5'b11000, 5'b11000, 2'd3, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check("async_rst", {9'd0, start, stage, frame_done}, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        s("post_rst", 1'b1, 1'b0, 5'b00000, 5'b00000, 2'd0, 1'b0, 1'b0);

        s("to_s1", 1'b1, 1'b0, 5'b00011, 5'b00011, 2'd1, 1'b0, 1'b0);
`ifdef FLOW_SEQ_TIMEOUT_EN
        for (int i = 1; i < 8; i++) begin
            s($sformatf("wd_wait%0d", i), 1'b1, 1'b0, 5'b00000, 5'b00000, 2'd1, 1'b0, 1'b0);
        end
        s("wd_fire", 1'b1, 1'b0, 5'b00000, 5'b00000, 2'd0, 1'b0, 1'b1);
        s("wd_sticky0", 1'b1, 1'b0, 5'b00011, 5'b00011, 2'd1, 1'b0, 1'b1);
        s("wd_sticky1", 1'b1, 1'b0, 5'b00100, 5'b00100, 2'd2, 1'b0, 1'b1);
        s("wd_clr", 1'b1, 1'b1, 5'b00000, 5'b00000, 2'd0, 1'b0, 1'b0);
        s("wd_after", 1'b1, 1'b0, 5'b00000, 5'b00000, 2'd0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 20; i++) begin
            s($sformatf("nowd_wait%0d", i), 1'b1, 1'b0, 5'b00000, 5'b00000, 2'd1, 1'b0, 1'b0);
        end
        s("nowd_go", 1'b1, 1'b0, 5'b00100, 5'b00100, 2'd2, 1'b0, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
